// File: rtl/p_reduce_acc.sv
// Frame accumulator: reduces the lanes of each beat with OR/AND/XOR and folds beats until in_last.
// Optional P_REDUCE_POPCOUNT_EN adds out_popcnt, the registered count of ones in out_bus.
module p_reduce_acc #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_INS    = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [1:0]                         op,
    input  logic [NB_INS*BUS_WIDTH-1:0]        in_buses,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [BUS_WIDTH-1:0]               out_bus,
    output logic [$clog2(MAX_BEATS+1)-1:0]     out_beats,
    output logic                               overflow,
    output logic                               out_valid,
`ifdef P_REDUCE_POPCOUNT_EN
    output logic [$clog2(BUS_WIDTH+1)-1:0]     out_popcnt,
`endif
    input  logic                               out_ready
);
    localparam int CW  = $clog2(MAX_BEATS+1);
    localparam int PCW = $clog2(BUS_WIDTH+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [BUS_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_beats;
    logic                 r_ovf;

    logic [BUS_WIDTH-1:0] w_or_chain  [NB_INS];
    logic [BUS_WIDTH-1:0] w_and_chain [NB_INS];
    logic [BUS_WIDTH-1:0] w_xor_chain [NB_INS];
    logic [1:0]           w_op_sel;
    logic [BUS_WIDTH-1:0] w_lane_red;
    logic [BUS_WIDTH-1:0] w_acc_next;
    logic                 w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < NB_INS; gi++) begin : g_lane
            if (gi == 0) begin : g_first
                assign w_or_chain[gi]  = in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
                assign w_and_chain[gi] = in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
                assign w_xor_chain[gi] = in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
            end else begin : g_rest
                assign w_or_chain[gi]  = w_or_chain[gi-1]  | in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
                assign w_and_chain[gi] = w_and_chain[gi-1] & in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
                assign w_xor_chain[gi] = w_xor_chain[gi-1] ^ in_buses[gi*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    endgenerate

    // The live op only matters on a frame's first beat; afterwards the latched copy rules.
    assign w_op_sel = (r_state == S_IDLE) ? op : r_op;
    assign in_ready = (r_state != S_HOLD);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_lane_red = w_or_chain[NB_INS-1];
        w_acc_next = w_or_chain[NB_INS-1];
        case (w_op_sel)
            2'b01: begin
                w_lane_red = w_and_chain[NB_INS-1];
                w_acc_next = r_acc & w_and_chain[NB_INS-1];
            end
            2'b10: begin
                w_lane_red = w_xor_chain[NB_INS-1];
                w_acc_next = r_acc ^ w_xor_chain[NB_INS-1];
            end
            default: begin
                w_lane_red = w_or_chain[NB_INS-1];
                w_acc_next = r_acc | w_or_chain[NB_INS-1];
            end
        endcase
        if (r_state == S_IDLE) begin
            w_acc_next = w_lane_red;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_acc   <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_acc   <= w_acc_next;
                        r_beats <= CW'(1);
                        r_ovf   <= 1'b0;
                        r_state <= in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_next;
                        // Only the count saturates; the data keeps folding.
                        if (r_beats == CW'(MAX_BEATS)) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_beats <= r_beats + CW'(1);
                        end
                        r_state <= in_last ? S_HOLD : S_ACCUM;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_bus   = r_acc;
    assign out_beats = r_beats;
    assign overflow  = r_ovf;
    assign out_valid = (r_state == S_HOLD);

`ifdef P_REDUCE_POPCOUNT_EN
    logic [PCW-1:0] r_popcnt;
    logic [PCW-1:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            w_popcnt = w_popcnt + PCW'(w_acc_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_popcnt <= '0;
        end else if (w_accept) begin
            r_popcnt <= w_popcnt;
        end
    end

    assign out_popcnt = r_popcnt;
`endif
endmodule

// File: tb/tb_p_reduce_acc.sv
// Scoreboard bench for p_reduce_acc: random and directed frames against a whole-frame fold model.
module tb_p_reduce_acc;
    localparam int BW = 8;
    localparam int NI = 4;
    localparam int MB = 16;
    localparam int CW = $clog2(MB+1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [NI*BW-1:0] in_buses = '0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic [BW-1:0]   out_bus;
    logic [CW-1:0]   out_beats;
    logic            overflow;
    logic            out_valid;
    logic            out_ready = 1'b0;
`ifdef P_REDUCE_POPCOUNT_EN
    logic [$clog2(BW+1)-1:0] out_popcnt;
`endif

    p_reduce_acc #(.BUS_WIDTH(BW), .NB_INS(NI), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .in_buses(in_buses),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_bus(out_bus), .out_beats(out_beats), .overflow(overflow),
        .out_valid(out_valid),
`ifdef P_REDUCE_POPCOUNT_EN
        .out_popcnt(out_popcnt),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0] bus;
        logic [CW-1:0] beats;
        logic          ovf;
    } exp_t;

    exp_t  exp_q[$];
    logic [NI*BW-1:0] beat_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    done = 0;
    int    n_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-frame fold: the op is applied over every lane of every beat in one pass.
    function automatic exp_t model(input logic [1:0] f_op, input int n);
        exp_t e;
        logic [BW-1:0] acc;
        logic [BW-1:0] lane;
        bit first = 1;
        acc = '0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < NI; k++) begin
                lane = beat_q[b][k*BW +: BW];
                if (first) acc = lane;
                else if (f_op == 2'b01) acc = acc & lane;
                else if (f_op == 2'b10) acc = acc ^ lane;
                else acc = acc | lane;
                first = 0;
            end
        end
        e.bus   = acc;
        e.beats = CW'((n > MB) ? MB : n);
        e.ovf   = (n > MB);
        return e;
    endfunction

    // Sends beat_q as one frame; op is scrambled after the first beat to prove it is ignored.
    task automatic send_frame(input logic [1:0] f_op, input bit with_last, input bit gaps);
        int n;
        int cnt;
        n = beat_q.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_last  = 1'($urandom);
                    in_buses = $urandom;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_buses = beat_q[i];
            in_last  = with_last && (i == n-1);
            op       = (i == 0) ? f_op : 2'($urandom);
            cnt = 0;
            while (!in_ready) begin
                @(negedge clk);
                cnt++;
                if (cnt > 1000) begin
                    n_cmp++; n_err++;
                    $display("FAIL in_ready_timeout: got 0 expected 1");
                    break;
                end
            end
        end
        if (with_last) exp_q.push_back(model(f_op, n));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (with_last) begin
            check("latency_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        beat_q.delete();
    endtask

    task automatic drain();
        int cnt = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(negedge clk);
            cnt++;
            if (cnt > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
                break;
            end
        end
    endtask

    // Monitor: owns out_ready, pops the scoreboard on each handshake and checks HOLD stability.
    initial begin
        exp_t e;
        bit stalled = 0;
        logic [BW-1:0] last_bus = '0;
        while (!done) begin
            @(negedge clk);
            if (stalled && rst_n) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bus_stable", 32'(out_bus), 32'(last_bus));
            end
            out_ready = ($urandom_range(0, 9) < 6);
            stalled = out_valid && !out_ready;
            last_bus = out_bus;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_result: got %0h expected none", out_bus);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bus", 32'(out_bus), 32'(e.bus));
                    check("out_beats", 32'(out_beats), 32'(e.beats));
                    check("overflow", 32'(overflow), 32'(e.ovf));
`ifdef P_REDUCE_POPCOUNT_EN
                    check("out_popcnt", 32'(out_popcnt), 32'($countones(e.bus)));
`endif
                    $display("frame %0d: bus=%02h beats=%0d ovf=%0b", n_frames, out_bus, out_beats, overflow);
                    n_frames++;
                end
            end
        end
    end

    initial begin
        int n;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bus", 32'(out_bus), 32'd0);
        check("rst_out_beats", 32'(out_beats), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        beat_q.push_back(32'h01020408);                      // OR one beat
        send_frame(2'b00, 1, 0);
        beat_q.push_back(32'hF1F3F0FF);                      // AND two beats
        beat_q.push_back(32'hF0FFF030);
        send_frame(2'b01, 1, 0);
        beat_q.push_back(32'h08040201);                      // XOR, then switch op mid-frame
        send_frame(2'b10, 1, 0);
        beat_q.push_back(32'h00FF0F33);
        beat_q.push_back(32'h0F0F0F0F);
        beat_q.push_back(32'hFFFFFFFF);
        send_frame(2'b10, 1, 0);
        for (int i = 0; i < 18; i++) beat_q.push_back(32'h00000001);  // saturating count
        send_frame(2'b00, 1, 0);
        beat_q.push_back(32'h00000A50);                      // popcount pattern {50,0A,00,00}
        send_frame(2'b00, 1, 0);

        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) beat_q.push_back($urandom);
            send_frame(2'($urandom), 1, 1);
        end

        drain();
        for (int i = 0; i < 3; i++) beat_q.push_back($urandom);
        send_frame(2'b00, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_out_beats", 32'(out_beats), 32'd0);
        check("async_rst_out_bus", 32'(out_bus), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat_q.push_back(32'h000000AA);
        send_frame(2'b00, 1, 0);
        drain();

        done = 1;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
